// File: rtl/gmux_qgate_ctrl.sv
// Per-quadrant clock-gate controller: static/dynamic enable selection with a
// sleep/wake sequencer per quadrant and glitch-free registered outputs.
module gmux_qgate_ctrl #(
  parameter int unsigned NQ          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SLEEP_DLY   = 4,
  parameter int unsigned WAKE_DLY    = 8
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          SSEL,
  input  logic [NQ-1:0] SEN,
  input  logic [NQ-1:0] DEN,
  input  logic [NQ-1:0] DYNEN,
  input  logic [NQ-1:0] VLP,
  output logic [NQ-1:0] QEN,
  output logic [NQ-1:0] QSLP,
  output logic          BUSY
);

  localparam int unsigned CW = 8;

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_ON       = 3'd1,
    S_SLP_WAIT = 3'd2,
    S_SLEEP    = 3'd3,
    S_WAKE     = 3'd4
  } state_t;

  state_t                          state_q [NQ];
  state_t                          state_d [NQ];
  logic   [CW-1:0]                 cnt_q   [NQ];
  logic   [CW-1:0]                 cnt_d   [NQ];
  logic   [SYNC_STAGES-1:0][NQ-1:0] den_sync;
  logic   [SYNC_STAGES-1:0][NQ-1:0] vlp_sync;
  logic   [NQ-1:0]                 den_s;
  logic   [NQ-1:0]                 vlp_s;
  logic   [NQ-1:0]                 req;
  logic   [NQ-1:0]                 qen_d;
  logic   [NQ-1:0]                 qslp_d;
  logic   [NQ-1:0]                 busy_vec;
  logic                            busy_d;

  // Synchronisers for the asynchronous DEN/VLP requests
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      den_sync <= '0;
      vlp_sync <= '0;
    end else begin
      den_sync <= {den_sync[SYNC_STAGES-2:0], DEN};
      vlp_sync <= {vlp_sync[SYNC_STAGES-2:0], VLP};
    end
  end

  assign den_s  = den_sync[SYNC_STAGES-1];
  assign vlp_s  = vlp_sync[SYNC_STAGES-1];
  assign req    = (DYNEN & den_s) | (~DYNEN & SEN);
  assign busy_d = |busy_vec;

  // Next-state and output decode; priority is SSEL, then vlp_s, then req
  always_comb begin
    qen_d    = '0;
    qslp_d   = '0;
    busy_vec = '0;
    for (int i = 0; i < int'(NQ); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        S_OFF: begin
          if (SSEL) begin
            state_d[i] = S_OFF;
          end else if (vlp_s[i]) begin
            state_d[i] = S_SLP_WAIT;
            cnt_d[i]   = CW'(SLEEP_DLY - 1);
          end else if (req[i]) begin
            state_d[i] = S_ON;
          end
        end
        S_ON: begin
          if (SSEL || vlp_s[i] || !req[i]) state_d[i] = S_OFF;
        end
        S_SLP_WAIT: begin
          if (SSEL || !vlp_s[i])      state_d[i] = S_OFF;
          else if (cnt_q[i] == '0)    state_d[i] = S_SLEEP;
          else                        cnt_d[i]   = cnt_q[i] - CW'(1);
        end
        S_SLEEP: begin
          if (SSEL) begin
            state_d[i] = S_OFF;
          end else if (!vlp_s[i]) begin
            state_d[i] = S_WAKE;
            cnt_d[i]   = CW'(WAKE_DLY - 1);
          end
        end
        S_WAKE: begin
          if (SSEL || cnt_q[i] == '0) state_d[i] = S_OFF;
          else                        cnt_d[i]   = cnt_q[i] - CW'(1);
        end
        default: begin
          state_d[i] = S_OFF;
          cnt_d[i]   = '0;
        end
      endcase
      qen_d[i]    = (state_d[i] == S_ON);
      qslp_d[i]   = (state_d[i] == S_SLEEP);
      busy_vec[i] = (state_d[i] == S_SLP_WAIT) || (state_d[i] == S_WAKE);
    end
  end

  // State, counters and outputs registered together so outputs mirror state
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < int'(NQ); i++) begin
        state_q[i] <= S_OFF;
        cnt_q[i]   <= '0;
      end
      QEN  <= '0;
      QSLP <= '0;
      BUSY <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NQ); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      QEN  <= qen_d;
      QSLP <= qslp_d;
      BUSY <= busy_d;
    end
  end

endmodule
